// File: rtl/signed_serial_multiplier.sv
// signed_serial_multiplier
// Two's-complement shift-add multiplier paced by a free-running frame
// sequencer. One operand pair is sampled at phase 0 of each 2*BITWIDTH-clock
// frame, one multiplier bit is consumed per clock, and the exact product is
// presented with a one-cycle strobe as the next frame begins.

module signed_serial_multiplier #(
   parameter int BITWIDTH = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    re,
   input  logic [BITWIDTH-1:0]     a,
   input  logic [BITWIDTH-1:0]     b,
   output logic                    data_in_valid,
   output logic                    data_out_valid,
   output logic [2*BITWIDTH-1:0]   dout,
   output logic [$clog2(2*BITWIDTH)-1:0] phase
);

   localparam int W  = BITWIDTH;
   localparam int F  = 2 * BITWIDTH;
   localparam int PW = $clog2(F);

   // Frame position classes derived from the phase counter.
   typedef enum logic [1:0] {
      R_CAPTURE,
      R_COMPUTE,
      R_IDLE,
      R_EMIT
   } region_t;

   region_t          region;
   logic             last_iter;
   logic [2*W-1:0]   mcand;     // sign-extended multiplicand, shifted left per iteration
   logic [W-1:0]     mplier;    // multiplier, shifted right so bit 0 is the current bit
   logic [2*W-1:0]   acc;
   logic [2*W-1:0]   addend;
   logic [2*W-1:0]   acc_next;

   // Upstream must present a/b exactly in the cycle this is high.
   assign data_in_valid = re & ~rst & (phase == '0);

   // Decode the current frame position into its role.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
      region    = R_IDLE;
      last_iter = 1'b0;
      if (phase == '0) begin
         region = R_CAPTURE;
      end else if (phase <= PW'(W)) begin
         region    = R_COMPUTE;
         last_iter = (phase == PW'(W));
      end else if (phase == PW'(F - 1)) begin
         region = R_EMIT;
      end
   end

   // Partial product for this iteration; the sign bit of B carries negative weight.
   always_comb begin
      addend   = mplier[0] ? mcand : '0;
      acc_next = last_iter ? (acc - addend) : (acc + addend);
   end

   // Phase counter, operand capture, shift-add datapath and result register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         phase          <= '0;
         mcand          <= '0;
         mplier         <= '0;
         acc            <= '0;
         dout           <= '0;
         data_out_valid <= 1'b0;
      end else if (!re) begin
         // Abandon any in-flight frame; dout keeps the last finished product.
         phase          <= '0;
         data_out_valid <= 1'b0;
      end else begin
         phase          <= (phase == PW'(F - 1)) ? '0 : phase + PW'(1);
         data_out_valid <= 1'b0;
         case (region)
            R_CAPTURE: begin
               mcand  <= {{W{a[W-1]}}, a};
               mplier <= b;
               acc    <= '0;
            end
            R_COMPUTE: begin
               acc    <= acc_next;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
            end
            R_EMIT: begin
               dout           <= acc;
               data_out_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_signed_serial_multiplier.sv
// Testbench for signed_serial_multiplier (BITWIDTH = 8, frame = 16 clocks).
// Corner products come from a constant table, random products from plain
// signed integer multiplication; frame timing is checked cycle by cycle.

module tb_signed_serial_multiplier;

   localparam int W = 8;
   localparam int F = 2 * W;

   logic                clk = 1'b0;
   logic                rst;
   logic                re;
   logic [W-1:0]        a;
   logic [W-1:0]        b;
   logic                data_in_valid;
   logic                data_out_valid;
   logic [2*W-1:0]      dout;
   logic [$clog2(F)-1:0] phase;

   int n_checks = 0;
   int n_pass   = 0;
   int last_dout = 0;   // product the bench expects dout to be holding

   typedef struct {
      logic signed [W-1:0] av;
      logic signed [W-1:0] bv;
      int                  exp;
      string               name;
   } vec_t;

   vec_t tbl[6];

   signed_serial_multiplier #(.BITWIDTH(W)) dut (
      .clk            (clk),
      .rst            (rst),
      .re             (re),
      .a              (a),
      .b              (b),
      .data_in_valid  (data_in_valid),
      .data_out_valid (data_out_valid),
      .dout           (dout),
      .phase          (phase)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Advance one clock and settle just after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Run one full frame starting in a phase-0 cycle with re=1, scrambling
   // a/b outside the capture cycle, and check the strobe 16 clocks later.
   task automatic do_frame(input logic signed [W-1:0] av,
                           input logic signed [W-1:0] bv,
                           input string name);
      int exp;
      bit ok;
      exp = int'(av) * int'(bv);
      check({name, "_din_valid"}, int'(data_in_valid), 1);
      a = av;
      b = bv;
      step();
      ok = 1'b1;
      for (int k = 1; k < F; k++) begin
         if (int'(phase) != k || data_out_valid || int'($signed(dout)) != last_dout) ok = 1'b0;
         a = W'($urandom);
         b = W'($urandom);
         step();
      end
      check({name, "_midframe"}, int'(ok), 1);
      check({name, "_strobe"}, int'(data_out_valid), 1);
      check({name, "_dout"}, int'($signed(dout)), exp);
      check({name, "_phase0"}, int'(phase), 0);
      last_dout = exp;
   endtask

   function automatic logic [W-1:0] pick_operand();
      logic [W-1:0] edges [5];
      edges = '{8'h80, 8'hFF, 8'h00, 8'h01, 8'h7F};
      if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 4)];
      return W'($urandom);
   endfunction

   initial begin
      bit ok;

      tbl[0] = '{-8'sd128, -8'sd128,  16384, "neg128_sq"};
      tbl[1] = '{ 8'sd127, -8'sd128, -16256, "pos127_neg128"};
      tbl[2] = '{-8'sd1,   -8'sd1,        1, "neg1_sq"};
      tbl[3] = '{ 8'sd0,   -8'sd77,       0, "zero_neg77"};
      tbl[4] = '{-8'sd128,  8'sd1,     -128, "neg128_one"};
      tbl[5] = '{ 8'sd7,    8'sd9,       63, "seven_nine"};

      // Reset state.
      rst = 1'b1; re = 1'b0; a = '0; b = '0;
      step();
      step();
      check("rst_phase", int'(phase), 0);
      check("rst_dout", int'(dout), 0);
      check("rst_dout_valid", int'(data_out_valid), 0);
      re = 1'b1;
      #1;
      check("rst_din_valid_blocked", int'(data_in_valid), 0);

      // Latency and back-to-back throughput.
      rst = 1'b0; re = 1'b0;
      step();
      re = 1'b1;
      #1;
      do_frame(8'sd5, -8'sd3, "latency");
      do_frame(8'sd2,  8'sd3, "throughput");

      // Corner table, back-to-back.
      foreach (tbl[i]) begin
         if (int'(tbl[i].av) * int'(tbl[i].bv) != tbl[i].exp)
            $display("table entry %s inconsistent", tbl[i].name);
         do_frame(tbl[i].av, tbl[i].bv, tbl[i].name);
      end

      // Random products against integer multiplication.
      for (int n = 0; n < 400; n++) begin
         do_frame(pick_operand(), pick_operand(), "random");
      end

      // re dropped at phase 5: frame abandoned, no strobe, dout held.
      a = 8'd11; b = 8'd13;
      step();
      for (int k = 1; k < 5; k++) step();
      check("abandon_at_phase5", int'(phase), 5);
      re = 1'b0;
      step();
      check("abandon_phase", int'(phase), 0);
      check("abandon_no_strobe", int'(data_out_valid), 0);
      check("abandon_dout_held", int'($signed(dout)), last_dout);
      ok = 1'b1;
      for (int k = 0; k < 20; k++) begin
         if (data_out_valid || phase != 0 || data_in_valid || int'($signed(dout)) != last_dout) ok = 1'b0;
         step();
      end
      check("abandon_idle", int'(ok), 1);
      re = 1'b1;
      #1;
      do_frame(-8'sd7, 8'sd6, "after_abandon");

      // Reset at phase 10 with a frame in flight.
      a = 8'd156; b = 8'd50;
      step();
      for (int k = 1; k < 10; k++) step();
      check("midrst_at_phase10", int'(phase), 10);
      rst = 1'b1;
      step();
      check("midrst_phase", int'(phase), 0);
      check("midrst_dout", int'(dout), 0);
      check("midrst_dout_valid", int'(data_out_valid), 0);
      check("midrst_din_valid", int'(data_in_valid), 0);
      last_dout = 0;
      rst = 1'b0;
      #1;
      do_frame(-8'sd128, 8'sd127, "post_rst");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
